fft_r2sdf_bf: RTL and testbench

Radix-2 single-path delay-feedback (R2SDF) butterfly stage for the streaming FFT datapath. It consumes one complex sample per clock. It owns the feedback delay line, built from two `shift_reg` instances, and feeds that delay line while consuming its output. It emits untwiddled butterfly results, with one bit of growth, to the downstream twiddle-multiply stage.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_r2sdf_bf_ctrl.sv | 76 +++++++
 rtl/shift_reg.sv | 41 ++++
 rtl/fft_r2sdf_bf.sv | 84 ++++++++
 tb/tb_fft_r2sdf_bf.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the streaming FFT butterfly stages.
package fft_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_LEN = 512;

    // Butterfly outputs carry one bit of growth over the input components.
    function automatic int cplx_width(input int data_width);
        return data_width + 1;
    endfunction

    // Frame counter spans 2*LEN samples: log2(LEN) index bits plus the phase bit.
    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/fft_r2sdf_bf_ctrl.sv
// Frame counter, phase select and the valid/sync/error flags for the R2SDF butterfly.
module fft_r2sdf_bf_ctrl
    import fft_pkg::*;
#(
    parameter int LEN = DEFAULT_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic phase_o,
    output logic out_en_o,
    output logic valid_o,
    output logic sync_o,
    output logic err_o
);

    localparam int              CW    = cnt_width(LEN);
    localparam logic [CW-1:0]   LEN_C = CW'(LEN);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          sync_q, sync_d;
    logic          err_q, err_d;

    // The start sample is index 0, so the counter is already at 1 on the first RUN cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        sync_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    state_d = ST_RUN;
                    cnt_d   = CW'(1);
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LEN_C) begin
                    valid_d = 1'b1;
                    sync_d  = 1'b1;
                end
                if (!valid_i) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
        end
    end

    assign phase_o  = (state_q == ST_RUN) && cnt_q[CW-1];
    assign out_en_o = valid_d;
    assign valid_o  = valid_q;
    assign sync_o   = sync_q;
    assign err_o    = err_q;

endmodule

// File: rtl/shift_reg.sv
// Fixed-length delay line as a circular buffer in block RAM with a registered read.
module shift_reg #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] dout_q;

    // Reading the slot that is overwritten next cycle makes the total delay exactly DEPTH.
    always_comb begin
        wp_d    = wp_q + AW'(1);
        rd_addr = wp_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        mem[wp_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q   <= '0;
            dout_q <= '0;
        end else begin
            wp_q   <= wp_d;
            dout_q <= mem[rd_addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/fft_r2sdf_bf.sv
// Radix-2 single-path delay-feedback butterfly: one complex sample per clock,
// untwiddled sums then differences with one bit of growth.
module fft_r2sdf_bf
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int LEN        = DEFAULT_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] re_i,
    input  logic [DATA_WIDTH-1:0] im_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH:0]   re_o,
    output logic [DATA_WIDTH:0]   im_o,
    output logic                  sync_o,
    output logic                  err_o
);

    localparam int OW = cplx_width(DATA_WIDTH);

    logic          phase;
    logic          out_en;
    logic [OW-1:0] x_c   [2];
    logic [OW-1:0] d_c   [2];
    logic [OW-1:0] din_c [2];
    logic [OW-1:0] res_c [2];
    logic [OW-1:0] re_q, re_d;
    logic [OW-1:0] im_q, im_d;

    // A missing sample contributes zero so the frame timing never slips.
    assign x_c[0] = valid_i ? {re_i[DATA_WIDTH-1], re_i} : '0;
    assign x_c[1] = valid_i ? {im_i[DATA_WIDTH-1], im_i} : '0;

    fft_r2sdf_bf_ctrl #(
        .LEN (LEN)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .phase_o  (phase),
        .out_en_o (out_en),
        .valid_o  (valid_o),
        .sync_o   (sync_o),
        .err_o    (err_o)
    );

    // Index 0 is the real path, index 1 the imaginary path.
    for (genvar gi = 0; gi < 2; gi++) begin : g_path
        assign din_c[gi] = phase ? (d_c[gi] - x_c[gi]) : x_c[gi];
        assign res_c[gi] = phase ? (d_c[gi] + x_c[gi]) : d_c[gi];

        shift_reg #(
            .WIDTH (OW),
            .DEPTH (LEN)
        ) u_delay (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din_c[gi]),
            .dout  (d_c[gi])
        );
    end

    // Data outputs stay zero until valid so stale delay-line words never leak out.
    always_comb begin
        re_d = out_en ? res_c[0] : '0;
        im_d = out_en ? res_c[1] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            re_q <= '0;
            im_q <= '0;
        end else begin
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    assign re_o = re_q;
    assign im_o = im_q;

endmodule

// File: tb/tb_fft_r2sdf_bf.sv
// Self-checking bench for fft_r2sdf_bf (LEN=4, DATA_WIDTH=8) against a frame-level butterfly model.
module tb_fft_r2sdf_bf;

    localparam int DW    = 8;
    localparam int L     = 4;
    localparam int MAXC  = 64;

    logic          clk;
    logic          rst_n;
    logic          valid_i;
    logic [DW-1:0] re_i, im_i;
    logic          valid_o;
    logic [DW:0]   re_o, im_o;
    logic          sync_o;
    logic          err_o;

    fft_r2sdf_bf #(
        .DATA_WIDTH (DW),
        .LEN        (L)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .re_i    (re_i),
        .im_i    (im_i),
        .valid_o (valid_o),
        .re_o    (re_o),
        .im_o    (im_o),
        .sync_o  (sync_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [DW-1:0] stim_re [MAXC];
    logic signed [DW-1:0] stim_im [MAXC];
    logic                 stim_v  [MAXC];
    int                   got_re  [MAXC];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int a;
        int b;
        int exp_sum;
        int exp_diff;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int xr(input int s);
        return stim_v[s] ? int'(stim_re[s]) : 0;
    endfunction

    function automatic int xi(input int s);
        return stim_v[s] ? int'(stim_im[s]) : 0;
    endfunction

    // Expected outputs at cycle c: output n is frame f = n/(2L), element k = n%(2L);
    // k < L gives x[k] + x[k+L], k >= L gives x[k-L] - x[k] of the same frame.
    task automatic check_cycle(input int c);
        int  n, k, base, er, ei;
        bit  ev, es, ee;
        ev = (c >= L + 1);
        ee = 1'b0;
        for (int s = 0; s < c; s++) if (!stim_v[s]) ee = 1'b1;
        er = 0; ei = 0; es = 1'b0;
        if (ev) begin
            n    = c - (L + 1);
            k    = n % (2 * L);
            base = n - k;
            es   = (k == 0);
            if (k < L) begin
                er = xr(base + k) + xr(base + k + L);
                ei = xi(base + k) + xi(base + k + L);
            end else begin
                er = xr(base + k - L) - xr(base + k);
                ei = xi(base + k - L) - xi(base + k);
            end
        end
        check($sformatf("valid_o@%0d", c), int'(valid_o), int'(ev));
        check($sformatf("sync_o@%0d", c), int'(sync_o), int'(es));
        check($sformatf("err_o@%0d", c), int'(err_o), int'(ee));
        check($sformatf("re_o@%0d", c), int'($signed(re_o)), er);
        check($sformatf("im_o@%0d", c), int'($signed(im_o)), ei);
    endtask

    // Reset for 3 cycles, idle with valid_i low, then stream n samples from the stim arrays.
    task automatic run_stream(input string tag, input int idle, input int n);
        for (int i = 0; i < MAXC; i++) got_re[i] = 0;
        rst_n = 1'b0; valid_i = 1'b0; re_i = '0; im_i = '0;
        repeat (3) @(negedge clk);
        check({tag, " reset valid_o"}, int'(valid_o), 0);
        check({tag, " reset sync_o"}, int'(sync_o), 0);
        check({tag, " reset err_o"}, int'(err_o), 0);
        check({tag, " reset re_o"}, int'(re_o), 0);
        check({tag, " reset im_o"}, int'(im_o), 0);
        rst_n = 1'b1;
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            check($sformatf("%s idle%0d", tag, i),
                  int'({valid_o, sync_o, err_o, re_o, im_o}), 0);
        end
        for (int c = 0; c < n; c++) begin
            valid_i = stim_v[c];
            re_i    = stim_re[c];
            im_i    = stim_im[c];
            @(negedge clk);
            check_cycle(c + 1);
            got_re[c + 1] = int'($signed(re_o));
        end
        $display("run %s: idle=%0d samples=%0d errors_so_far=%0d", tag, idle, n, errors);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < MAXC; i++) begin
            stim_re[i] = (i < n) ? DW'($urandom_range(0, 255)) : '0;
            stim_im[i] = (i < n) ? DW'($urandom_range(0, 255)) : '0;
            stim_v[i]  = 1'b1;
        end
    endtask

    int ramp_exp [8];

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; re_i = '0; im_i = '0;

        vecs[0] = '{a: -128, b: -128, exp_sum: -256, exp_diff: 0};
        vecs[1] = '{a: 127,  b: -128, exp_sum: -1,   exp_diff: 255};
        vecs[2] = '{a: -128, b: 127,  exp_sum: -1,   exp_diff: -255};
        vecs[3] = '{a: 5,    b: 3,    exp_sum: 8,    exp_diff: 2};
        ramp_exp = '{6, 8, 10, 12, -4, -4, -4, -4};

        // Reset then a long idle stretch.
        for (int i = 0; i < MAXC; i++) begin
            stim_re[i] = '0; stim_im[i] = '0; stim_v[i] = 1'b1;
        end
        run_stream("idle", 20, 0);

        // Ramp 1..8 followed by a zero frame to flush the differences.
        for (int i = 0; i < MAXC; i++) begin
            stim_re[i] = (i < 8) ? DW'(i + 1) : '0;
            stim_im[i] = '0;
            stim_v[i]  = 1'b1;
        end
        run_stream("ramp", 2, 12);
        for (int k = 0; k < 8; k++)
            check($sformatf("ramp re_o[%0d]", k), got_re[L + 1 + k], ramp_exp[k]);

        // Table of extreme operand pairs: constant phase-0 and phase-1 values.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < MAXC; i++) begin
                stim_re[i] = (i < L) ? DW'(vecs[v].a) : (i < 2 * L) ? DW'(vecs[v].b) : '0;
                stim_im[i] = '0;
                stim_v[i]  = 1'b1;
            end
            run_stream($sformatf("ext%0d", v), 1, 12);
            check($sformatf("ext%0d sum", v), got_re[L + 1], vecs[v].exp_sum);
            check($sformatf("ext%0d diff", v), got_re[2 * L + 1], vecs[v].exp_diff);
        end

        // Five back-to-back random frames plus the flush of the last differences.
        fill_random(40);
        run_stream("frames", 3, 44);

        // One-cycle gap mid phase 1: the sum and diff both reduce to d.
        fill_random(20);
        stim_v[L + 1] = 1'b0;
        run_stream("gap", 1, 20);
        check("gap sum", got_re[L + 2], xr(1));
        check("gap diff", got_re[2 * L + 2], xr(1));

        // Reset during phase 1 of the second frame, then restart immediately.
        fill_random(14);
        run_stream("pre_reset", 0, 2 * L + L + 2);
        fill_random(24);
        run_stream("post_reset", 0, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
